// File: rtl/seq_leftshifter.sv
// -----------------------------------------------------------------------------
// seq_leftshifter
//
// Multi-cycle 32-bit logical left shifter. An operand and a 5-bit shift amount
// are accepted over a valid/ready handshake. The shift is resolved over five
// clocked stages of distance 16, 8, 4, 2 and 1. Each stage is applied only when
// its bit of the shift amount is set. The result is held in a register until
// the consumer takes it. A sticky flag reports whether any 1 bit was pushed
// out past bit 31.
//
// Latency is fixed at 5 cycles from accept to out_valid, even for shamt = 0.
//
// Ports
//   clock      in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   in_valid   in   1  operand presented
//   in_ready   out  1  block can accept an operand (IDLE and not in reset)
//   a          in  32  operand, sampled on the accept edge
//   shamt      in   5  shift amount, sampled on the accept edge
//   out_valid  out  1  out/lost hold a completed result
//   out_ready  in   1  consumer takes the result
//   out        out 32  a << shamt, zero-filled from bit 0
//   lost       out  1  1 if any bit shifted past bit 31 was 1
//   busy       out  1  operation in flight or result not yet taken
// -----------------------------------------------------------------------------
module seq_leftshifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        lost,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_amt;
  logic [2:0]  r_stage;
  logic        r_lost;

  logic [4:0]  w_dist;
  logic        w_take;
  logic [31:0] w_shifted;
  logic [31:0] w_drop_mask;
  logic        w_drop;

  // Stage k shifts by 16>>k and is gated by amt[4-k]. The stages run from the
  // largest distance to the smallest.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    w_dist = 5'd0;
    w_take = 1'b0;
    case (r_stage)
      3'd0:    begin w_dist = 5'd16; w_take = r_amt[4]; end
      3'd1:    begin w_dist = 5'd8;  w_take = r_amt[3]; end
      3'd2:    begin w_dist = 5'd4;  w_take = r_amt[2]; end
      3'd3:    begin w_dist = 5'd2;  w_take = r_amt[1]; end
      3'd4:    begin w_dist = 5'd1;  w_take = r_amt[0]; end
      default: begin w_dist = 5'd0;  w_take = 1'b0;     end
    endcase
    w_shifted   = r_acc << w_dist;
    // The top d bits of acc, acc[31:32-d], are the ones this stage drops.
    w_drop_mask = ~(32'hFFFF_FFFF >> w_dist);
    w_drop      = |(r_acc & w_drop_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments, so every
      // register samples the values from before this edge.
      r_state <= S_IDLE;
      r_acc   <= 32'd0;
      r_amt   <= 5'd0;
      r_stage <= 3'd0;
      r_lost  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc   <= a;
            r_amt   <= shamt;
            r_stage <= 3'd0;
            r_lost  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_take) begin
            r_acc  <= w_shifted;
            r_lost <= r_lost | w_drop;
          end
          if (r_stage == 3'd4) begin
            r_state <= S_DONE;
          end else begin
            r_stage <= r_stage + 3'd1;
          end
        end
        S_DONE: begin
          // out/lost stay in r_acc/r_lost after the handoff. They change only
          // at the next accept.
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The handshake outputs are decoded from state only. in_ready also depends
  // on reset, and neither output has a path from the other side's valid/ready.
  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out       = r_acc;
  assign lost      = r_lost;

endmodule
